dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024, data RAM depth in 32-bit words (power of two); AW = log2(DEPTH).
REQ-002 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port req_valid  input  1  CPU memory request present.
REQ-005 Port req_ready  output  1  controller can accept a request this cycle.
REQ-006 Port ena  input  1  data-region write enable from the address decoder (high only for we=1 and addr[31:28]=0).
REQ-007 Port we  input  1  1 = store, 0 = load.
REQ-008 Port addr  input  32  byte address.
REQ-009 Port wdata  input  32  store data, right-aligned.
REQ-010 Port size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-011 Port sign_ext  input  1  loads: 1 sign-extend, 0 zero-extend.
REQ-012 Port rdata  output  32  load result, right-aligned and extended.
REQ-013 Port rvalid  output  1  one-cycle pulse, rdata valid.
REQ-014 Port err  output  1  one-cycle misalignment pulse.

Function
REQ-015 Request accepted in a cycle with req_valid=1 and req_ready=1; all inputs sampled in that cycle.
REQ-016 FSM states IDLE, RD_WAIT; req_ready=1 only in IDLE.
REQ-017 IDLE + accepted load -> RD_WAIT; IDLE + accepted store -> IDLE; RD_WAIT -> IDLE unconditionally next cycle.
REQ-018 Word index = addr[AW+1:2]; higher bits ignored, index wraps modulo DEPTH.
REQ-019 Store with ena=1 writes RAM at the accept edge: byte writes lane addr[1:0] with wdata[7:0]; halfword writes lanes {addr[1],0..1} with wdata[15:0]; word writes all four lanes.
REQ-020 Store with ena=0 consumed, RAM unchanged, no rvalid, no err.
REQ-021 Load: rvalid=1 and rdata updated exactly one cycle after accept (in RD_WAIT); max load throughput one per two cycles.
REQ-022 Load extraction: byte lane addr[1:0], halfword lanes by addr[1], word whole; bits above extended per sign_ext.
REQ-023 rdata holds its value between loads; rvalid low except REQ-021 pulse.
REQ-024 Store accepted cycle N followed by load to same word accepted cycle N+1 returns the newly stored data.
REQ-025 Store inputs ignored for RAM purposes when req_ready=0.

Reset
REQ-026 While rst=1: state IDLE, req_ready=1 on cycle after rst deasserts (held 0 during rst), rvalid=0, rdata=0, err=0.
REQ-027 rst during RD_WAIT cancels the load: no rvalid pulse follows.
REQ-028 RAM contents not cleared by reset; no store occurs in a cycle with rst=1.

Configuration
REQ-029 Macro DMEM_ALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 is misaligned; misaligned store writes nothing; misaligned load returns rdata=0; err pulses one cycle after accept (both loads and stores; loads coincide with rvalid).
REQ-030 Macro undefined: err tied 0; word accesses ignore addr[1:0]; halfword ignores addr[0].

Structure
REQ-031 Package dmem_pkg holds size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state type, DEPTH default.
REQ-032 Sub-module dmem_ram: single-port DEPTH x 32 RAM, 4 byte-write enables, synchronous read; dmem_ctrl holds FSM, lane steering, extension, alignment check.

Verification
REQ-033 Reset, then word store 0xDEADBEEF to 0x00000010 (ena=1), load word -> rvalid one cycle after accept, rdata=0xDEADBEEF.
REQ-034 Byte load addr 0x00000013 sign_ext=1 -> rdata=0xFFFFFFDE; sign_ext=0 -> 0x000000DE; half load 0x00000010 sign_ext=1 -> 0xFFFFBEEF.
REQ-035 Byte store 0x55 to 0x00000011 then immediate load word 0x00000010 -> 0xDEAD55EF.
REQ-036 Store word 0x12345678 with ena=0 to 0x00000010 -> later load still returns previous contents; req_ready back-to-back during stores, low in RD_WAIT.
REQ-037 With DMEM_ALIGN_CHECK_EN: word load 0x00000012 -> rvalid=1, rdata=0, err=1 one cycle; word store 0x00000011 -> RAM unchanged, err=1.
REQ-038 Assert rst in RD_WAIT -> no rvalid; address 0x00001010 with DEPTH=1024 aliases to word 4 (wrap).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, size encodings and the load extraction helper for the data-memory controller.
package dmem_pkg;

  localparam int unsigned DEPTH_DEFAULT = 1024;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {IDLE, RD_WAIT} state_e;

  // Pick the addressed lane(s) out of a RAM word and right-align with sign/zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic sign_ext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: v = {{24{sign_ext & b[7]}}, b};
      SZ_HALF: v = {{16{sign_ext & h[15]}}, h};
      default: v = word;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and registered read data.
module dmem_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Read data only changes on a read access, so it holds across stores and idle cycles.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: request FSM, byte-lane steering and load extension over dmem_ram.
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        ena,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e      r_state, w_state_next;
  logic        w_accept, w_mis, w_ram_en;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_lanes, w_ram_rdata, w_ext;
  logic [1:0]  r_lane, r_size;
  logic        r_sign, r_mis, r_err;
  logic [31:0] r_hold;
  logic        w_unused_addr;

  assign w_accept      = req_valid & req_ready;
  assign w_unused_addr = ^addr[31:AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis = ((size == SZ_HALF) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    w_be          = 4'b1111;
    w_wdata_lanes = wdata;
    case (size)
      SZ_BYTE: begin
        w_be          = 4'b0001 << addr[1:0];
        w_wdata_lanes = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be          = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_lanes = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Loads always read; stores touch the RAM only when enabled and aligned.
  assign w_ram_en = w_accept & (~we | (ena & ~w_mis));

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_en    (w_ram_en),
    .i_we    (we),
    .i_be    (w_be),
    .i_addr  (addr[AW+1:2]),
    .i_wdata (w_wdata_lanes),
    .o_rdata (w_ram_rdata)
  );

  assign w_ext = r_mis ? 32'h0 : load_extract(w_ram_rdata, r_lane, r_size, r_sign);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && !we) w_state_next = RD_WAIT;
      RD_WAIT: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE) & ~rst;
    rvalid    = (r_state == RD_WAIT) & ~rst;
    err       = r_err & ~rst;
    rdata     = rst ? 32'h0 : (rvalid ? w_ext : r_hold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane <= 2'b00;
      r_size <= SZ_WORD;
      r_sign <= 1'b0;
      r_mis  <= 1'b0;
      r_err  <= 1'b0;
      r_hold <= 32'h0;
    end else begin
      r_err <= w_accept & w_mis;
      if (w_accept && !we) begin
        r_lane <= addr[1:0];
        r_size <= size;
        r_sign <= sign_ext;
        r_mis  <= w_mis;
      end
      if (r_state == RD_WAIT) r_hold <= w_ext;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl against an array-based memory model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst, req_valid, ena, we, sign_ext;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        req_ready, rvalid, err;
  logic [31:0] rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem_model [1024];
  logic [31:0] last_rdata;

  dmem_ctrl #(.DEPTH(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .ena       (ena),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .size      (size),
    .sign_ext  (sign_ext),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic ref_mis(input logic [31:0] a, input logic [1:0] sz);
`ifdef DMEM_ALIGN_CHECK_EN
    if (sz == 2'd1) return a[0];
    if (sz >= 2'd2) return (a[1:0] != 2'd0);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sg);
    logic [31:0] w, v;
    int off;
    if (ref_mis(a, sz)) return 32'h0;
    w = mem_model[a[11:2]];
    if (sz == 2'd0) begin
      off = int'(a[1:0]) * 8;
      v = (w >> off) & 32'hFF;
      if (sg && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      off = a[1] ? 16 : 0;
      v = (w >> off) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input logic en);
    logic [31:0] mask, dv;
    int off;
    if (!en || ref_mis(a, sz)) return;
    if (sz == 2'd0) begin
      off = int'(a[1:0]) * 8;
      mask = 32'hFF << off;
      dv = (d & 32'hFF) << off;
    end else if (sz == 2'd1) begin
      off = a[1] ? 16 : 0;
      mask = 32'hFFFF << off;
      dv = (d & 32'hFFFF) << off;
    end else begin
      mask = 32'hFFFF_FFFF;
      dv = d;
    end
    mem_model[a[11:2]] = (mem_model[a[11:2]] & ~mask) | dv;
  endtask

  // Entered and left at a negedge; the store is accepted on the intervening posedge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input logic en, input string tag);
    logic exp_err;
    exp_err   = ref_mis(a, sz);
    req_valid = 1'b1;
    we        = 1'b1;
    ena       = en;
    addr      = a;
    wdata     = d;
    size      = sz;
    sign_ext  = 1'($urandom);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s store_ready: got %b want 1", tag, req_ready);
    end
    @(posedge clk);
    ref_store(a, d, sz, en);
    @(negedge clk);
    req_valid = 1'b0;
    we        = 1'b0;
    ena       = 1'b0;
    n_cmp++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL %s store_err addr=%h: got %b want %b", tag, a, err, exp_err);
    end
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s store_rvalid: got %b want 0", tag, rvalid);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         input logic [31:0] exp, input string tag);
    logic exp_err;
    exp_err   = ref_mis(a, sz);
    req_valid = 1'b1;
    we        = 1'b0;
    ena       = 1'b0;
    addr      = a;
    wdata     = $urandom;
    size      = sz;
    sign_ext  = sg;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s load_ready: got %b want 1", tag, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s load_rvalid: got %b want 1", tag, rvalid);
    end
    n_cmp++;
    if (rdata !== exp) begin
      n_fail++;
      $display("FAIL %s load_rdata addr=%h sz=%0d sg=%b: got %h want %h", tag, a, sz, sg,
               rdata, exp);
    end
    n_cmp++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL %s load_err addr=%h: got %b want %b", tag, a, err, exp_err);
    end
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s rdwait_ready: got %b want 0", tag, req_ready);
    end
    last_rdata = exp;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (rvalid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post_load_pulse: got rvalid=%b err=%b want 0/0", tag, rvalid, err);
    end
    n_cmp++;
    if (rdata !== last_rdata) begin
      n_fail++;
      $display("FAIL %s rdata_hold: got %h want %h", tag, rdata, last_rdata);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0; ena = 1'b0; we = 1'b0; addr = '0; wdata = '0; size = '0; sign_ext = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got ready=%b rvalid=%b err=%b rdata=%h want 0/0/0/0",
               req_ready, rvalid, err, rdata);
    end
    rst = 1'b0;
    last_rdata = 32'h0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b rvalid=%b rdata=%h want 1/0/0",
               req_ready, rvalid, rdata);
    end
  endtask

  task automatic test_init;
    for (int i = 0; i < 1024; i++) do_store(i * 4, $urandom, 2'd2, 1'b1, "init");
  endtask

  task automatic test_basic;
    do_store(32'h10, 32'hDEAD_BEEF, 2'd2, 1'b1, "st_word");
    do_load(32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, "ld_word");
    do_load(32'h13, 2'd0, 1'b1, 32'hFFFF_FFDE, "ld_byte_sx");
    do_load(32'h13, 2'd0, 1'b0, 32'h0000_00DE, "ld_byte_zx");
    do_load(32'h10, 2'd1, 1'b1, 32'hFFFF_BEEF, "ld_half_sx");
    do_load(32'h12, 2'd1, 1'b0, 32'h0000_DEAD, "ld_half_hi");
    do_store(32'h11, 32'h0000_0055, 2'd0, 1'b1, "st_byte");
    do_load(32'h10, 2'd2, 1'b0, 32'hDEAD_55EF, "st_ld_fwd");
  endtask

  task automatic test_back_to_back;
    do_store(32'h10, 32'h1234_5678, 2'd2, 1'b0, "st_ena0_a");
    do_store(32'h10, 32'h8765_4321, 2'd3, 1'b0, "st_ena0_b");
    do_store(32'h24, 32'hA5A5_0F0F, 2'd2, 1'b1, "st_b2b");
    do_load(32'h10, 2'd2, 1'b0, 32'hDEAD_55EF, "ld_after_ena0");
    do_load(32'h24, 2'd3, 1'b0, 32'hA5A5_0F0F, "ld_size3");
  endtask

  task automatic test_wrap;
    do_load(32'h0000_1010, 2'd2, 1'b0, 32'hDEAD_55EF, "ld_alias");
    do_store(32'hF000_2014, 32'h0BAD_CAFE, 2'd2, 1'b1, "st_alias");
    do_load(32'h14, 2'd2, 1'b0, 32'h0BAD_CAFE, "ld_unalias");
  endtask

  task automatic test_align;
`ifdef DMEM_ALIGN_CHECK_EN
    do_load(32'h12, 2'd2, 1'b0, 32'h0, "ld_misaligned");
    do_store(32'h11, 32'hCAFE_F00D, 2'd2, 1'b1, "st_misaligned");
    do_load(32'h10, 2'd2, 1'b0, 32'hDEAD_55EF, "ld_after_mis_st");
    do_load(32'h11, 2'd1, 1'b0, 32'h0, "ld_half_mis");
`else
    do_load(32'h12, 2'd2, 1'b0, 32'hDEAD_55EF, "ld_word_ign_lsb");
    do_store(32'h11, 32'hCAFE_F00D, 2'd2, 1'b1, "st_word_ign_lsb");
    do_load(32'h10, 2'd2, 1'b0, 32'hCAFE_F00D, "ld_after_st_ign");
    do_load(32'h11, 2'd1, 1'b0, 32'h0000_F00D, "ld_half_ign_lsb");
`endif
  endtask

  task automatic test_rst_rdwait;
    req_valid = 1'b1; we = 1'b0; addr = 32'h10; size = 2'd2; sign_ext = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    n_cmp++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rdwait_now: got rvalid=%b rdata=%h want 0/0", rvalid, rdata);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_rdata = 32'h0;
    #1;
    n_cmp++;
    if (rvalid !== 1'b0 || rdata !== 32'h0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rdwait_after: got rvalid=%b rdata=%h ready=%b want 0/0/1",
               rvalid, rdata, req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rdwait_late: got rvalid=%b want 0", rvalid);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, d;
    logic [1:0]  sz;
    logic        sg;
    for (int i = 0; i < 400; i++) begin
      a  = $urandom;
      d  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        do_store(a, d, sz, ($urandom_range(0, 4) != 0), "rnd_st");
      end else begin
        sg = 1'($urandom);
        do_load(a, sz, sg, ref_load(a, sz, sg), "rnd_ld");
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_align();
    test_rst_rdwait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
